// File: rtl/wb_axisout_bridge_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | wb_axisout_bridge_if : Wishbone slave bus plus FIR result stream bundle   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface wb_axisout_bridge_if #(
    parameter int pDATA_WIDTH = 32
);
    logic                   wbs_stb_i;
    logic                   wbs_cyc_i;
    logic                   wbs_we_i;
    logic [3:0]             wbs_sel_i;
    logic [31:0]            wbs_dat_i;
    logic [31:0]            wbs_adr_i;
    logic                   wbs_ack_o;
    logic [31:0]            wbs_dat_o;
    logic                   sm_tvalid;
    logic [pDATA_WIDTH-1:0] sm_tdata;
    logic                   sm_tlast;
    logic                   sm_tready;

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        input  sm_tvalid, sm_tdata, sm_tlast,
        output wbs_ack_o, wbs_dat_o, sm_tready
    );

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        output sm_tvalid, sm_tdata, sm_tlast,
        input  wbs_ack_o, wbs_dat_o, sm_tready
    );
endinterface
`default_nettype wire

// File: rtl/wb_axisout_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | wb_axisout_bridge : FIR result stream into a FIFO, drained by Wishbone     |
// | polling/popping. Optional frame counter: AXISOUT_FRAME_CNT_EN. Rev 1.0    |
// +--------------------------------------------------------------------------+
module wb_axisout_bridge #(
    parameter int pDATA_WIDTH = 32,
    parameter int FIFO_DEPTH  = 4,
    parameter int pADDR_WIDTH = 12
) (
    input  wire logic          wb_clk_i,
    input  wire logic          wb_rst_ni,
    wb_axisout_bridge_if.slave bus
);
    localparam int         PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [3:0] DEPTH_CNT = 4'(FIFO_DEPTH);
    localparam logic [7:0] OFF_DATA  = 8'h84;
    localparam logic [7:0] OFF_STAT  = 8'h8C;
    localparam logic [7:0] OFF_FLUSH = 8'h90;
`ifdef AXISOUT_FRAME_CNT_EN
    localparam logic [7:0] OFF_FRAME = 8'h98;
`endif
    localparam int         unused_addr_width = pADDR_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD_DATA  = 3'd1,
        S_RD_STAT  = 3'd2,
        S_RD_OTHER = 3'd3,
        S_WR       = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    state_t                 state_q, state_d;
    logic [7:0]             off_q, off_d;
    logic                   wdat0_q, wdat0_d;
    logic                   live_q, live_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [3:0]             count_q, count_d;
    logic                   underflow_q, underflow_d;
    logic                   last_popped_q, last_popped_d;
    logic [pDATA_WIDTH:0]   mem_q [FIFO_DEPTH];
    logic [pDATA_WIDTH:0]   mem_d [FIFO_DEPTH];
`ifdef AXISOUT_FRAME_CNT_EN
    logic [15:0]            frame_q, frame_d;
`endif

    logic                   req, empty, full, tready, push, pop, flush;
    logic                   ack;
    logic [31:0]            rdata;
    logic [31:0]            status;
    logic [pDATA_WIDTH:0]   head;
    logic                   unused_bits;

    assign req    = bus.wbs_stb_i & bus.wbs_cyc_i & (bus.wbs_adr_i[31:24] == 8'h30);
    assign empty  = (count_q == 4'd0);
    assign full   = (count_q == DEPTH_CNT);
    assign head   = mem_q[rd_ptr_q];
    // live_q keeps tready low until the first clock after reset release
    assign tready = live_q & ~full;
    assign push   = bus.sm_tvalid & tready;
    assign pop    = (state_q == S_RD_DATA) & ~empty;
    assign flush  = (state_q == S_WR) & (off_q == OFF_FLUSH) & wdat0_q;
    assign status = {24'b0, count_q, underflow_q, last_popped_q, full, empty};

    assign unused_bits = ^{bus.wbs_sel_i, bus.wbs_adr_i[23:8], bus.wbs_dat_i[31:1]};

    assign bus.wbs_ack_o = ack;
    assign bus.wbs_dat_o = rdata;
    assign bus.sm_tready = tready;

    always_comb begin
        state_d = state_q;
        off_d   = off_q;
        wdat0_d = wdat0_q;
        ack     = 1'b0;
        rdata   = 32'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    off_d   = bus.wbs_adr_i[7:0];
                    wdat0_d = bus.wbs_dat_i[0];
                    if (bus.wbs_we_i)                      state_d = S_WR;
                    else if (bus.wbs_adr_i[7:0] == OFF_DATA) state_d = S_RD_DATA;
                    else if (bus.wbs_adr_i[7:0] == OFF_STAT) state_d = S_RD_STAT;
                    else                                   state_d = S_RD_OTHER;
                end
            end
            S_RD_DATA: begin
                ack     = 1'b1;
                rdata   = empty ? 32'b0 : 32'(head[pDATA_WIDTH-1:0]);
                state_d = S_DONE;
            end
            S_RD_STAT: begin
                ack     = 1'b1;
                rdata   = status;
                state_d = S_DONE;
            end
            S_RD_OTHER: begin
                ack     = 1'b1;
`ifdef AXISOUT_FRAME_CNT_EN
                if (off_q == OFF_FRAME) rdata = {16'b0, frame_q};
`endif
                state_d = S_DONE;
            end
            S_WR: begin
                ack     = 1'b1;
                state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FIFO bookkeeping; flush overrides any push or pop of the same cycle
    always_comb begin
        live_d        = 1'b1;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        underflow_d   = underflow_q;
        last_popped_d = last_popped_q;
        mem_d         = mem_q;
`ifdef AXISOUT_FRAME_CNT_EN
        frame_d       = frame_q;
`endif
        if (flush) begin
            wr_ptr_d      = '0;
            rd_ptr_d      = '0;
            count_d       = 4'd0;
            underflow_d   = 1'b0;
            last_popped_d = 1'b0;
`ifdef AXISOUT_FRAME_CNT_EN
            frame_d       = 16'd0;
`endif
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = {bus.sm_tlast, bus.sm_tdata};
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d      = rd_ptr_q + PTR_W'(1);
                last_popped_d = head[pDATA_WIDTH];
`ifdef AXISOUT_FRAME_CNT_EN
                if (head[pDATA_WIDTH]) frame_d = frame_q + 16'd1;
`endif
            end
            if ((state_q == S_RD_DATA) && empty) underflow_d = 1'b1;
            count_d = count_q + 4'(push) - 4'(pop);
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q       <= S_IDLE;
            off_q         <= 8'h00;
            wdat0_q       <= 1'b0;
            live_q        <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= 4'd0;
            underflow_q   <= 1'b0;
            last_popped_q <= 1'b0;
`ifdef AXISOUT_FRAME_CNT_EN
            frame_q       <= 16'd0;
`endif
        end else begin
            state_q       <= state_d;
            off_q         <= off_d;
            wdat0_q       <= wdat0_d;
            live_q        <= live_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            underflow_q   <= underflow_d;
            last_popped_q <= last_popped_d;
`ifdef AXISOUT_FRAME_CNT_EN
            frame_q       <= frame_d;
`endif
        end
    end

    // Storage holds no reset; validity is tracked entirely by the pointers
    always_ff @(posedge wb_clk_i) begin
        mem_q <= mem_d;
    end
endmodule
`default_nettype wire

// File: doc/wb_axisout_bridge.md
Name: wb_axisout_bridge

Overview:
- Downstream companion to the Wishbone-to-AXIS input bridge; sits at the FIR output.
- Accepts the FIR result stream (sm_* AXI-Stream master side) into a small FIFO.
- The Caravel Wishbone master reads results by polling status and popping data through memory-mapped registers at the 0x30xx_xxxx user window.

Parameters:
- pDATA_WIDTH, 32, stream and Wishbone data width.
- FIFO_DEPTH, 4, result FIFO entries; power of 2, legal range 2..8.
- pADDR_WIDTH, 12, kept for interface uniformity; only wbs_adr_i[7:0] is used as the register offset.

Ports:
- wb_clk_i  in  1  single clock for the Wishbone and stream sides
- wb_rst_ni  in  1  reset, asynchronous assert, active-low
- wbs_stb_i  in  1  Wishbone strobe
- wbs_cyc_i  in  1  Wishbone cycle
- wbs_we_i  in  1  Wishbone write enable
- wbs_sel_i  in  4  byte selects; ignored, full-word access only
- wbs_dat_i  in  32  write data
- wbs_adr_i  in  32  address; decoded when [31:24]==8'h30
- wbs_ack_o  out  1  Wishbone acknowledge
- wbs_dat_o  out  32  read data
- sm_tvalid  in  1  result stream valid
- sm_tdata  in  pDATA_WIDTH  result stream data
- sm_tlast  in  1  last beat of frame
- sm_tready  out  1  result stream ready

Behaviour:
- Reset (wb_rst_ni=0, asynchronous):
  - wbs_ack_o=0, wbs_dat_o=0, sm_tready=0.
  - FIFO pointers, count, sticky bits and FSM are cleared; FSM goes to IDLE.
- Register map (offset = wbs_adr_i[7:0]):
  - 0x84 R: pop data.
  - 0x8C R: status = {24'b0, count[3:0], underflow, last_popped, full, empty}.
  - 0x90 W: bit0=1 flushes; other bits ignored.
  - Reads of any other decoded offset return 0. Writes to any other decoded offset are acked and ignored.
- Request detection:
  - req = stb & cyc & decoded.
  - Non-decoded accesses are never acked.
- FSM states and transitions (ack is one cycle after the request is seen):
  - IDLE: req & ~we & off==0x84 -> RD_DATA; req & ~we & off==0x8C -> RD_STAT; req & ~we & other offset -> RD_OTHER; req & we -> WR.
  - RD_DATA, RD_STAT, RD_OTHER and WR each last 1 cycle with wbs_ack_o=1, then go to DONE.
  - DONE: ack=0; returns to IDLE unconditionally. This absorbs the master's stb drop.
- Read data:
  - wbs_dat_o is valid only in ack cycles and is 0 otherwise.
  - RD_DATA: wbs_dat_o = FIFO head, or 0 if empty.
  - RD_STAT: status word sampled in that cycle.
- Pop:
  - Occurs on the clock edge ending RD_DATA, only if the FIFO is not empty.
  - last_popped <= tlast bit stored with the popped entry.
  - RD_DATA while empty: returns 0, no pop, sets the sticky underflow bit.
- Push:
  - sm_tready = ~full (0 while in reset).
  - Beat accepted when sm_tvalid & sm_tready; {tlast,tdata} written at the write pointer.
- Pointers: log2(FIFO_DEPTH) bits, wrap naturally. count is 0..FIFO_DEPTH.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Pop at count==FIFO_DEPTH frees the slot the next cycle; sm_tready rises the following cycle, with no same-cycle bypass.
- Flush (WR with dat[0]=1, applied at the WR edge):
  - Clears pointers, count, underflow and last_popped.
  - A stream beat accepted in the same cycle is discarded; flush wins.
- Reset mid-transaction: ack drops immediately and the master must retry.

Optional Feature:
- Macro: AXISOUT_FRAME_CNT_EN.
- With the macro:
  - A 16-bit frame counter increments on each pop whose entry has tlast=1, and wraps at 0xFFFF->0.
  - Readable at 0x98 as {16'b0, frame_cnt}.
  - Cleared by reset and by flush.
- Without the macro: no counter logic; 0x98 behaves as an unused offset (reads 0).

Test Plan:
- Reset release, FIFO empty -> sm_tready=1 next cycle; read 0x3000008C returns 0x00000001; ack exactly one cycle, 2nd clock after stb.
- Stream 3 beats 0x11,0x22,0x33 (tlast on 0x33), then read 0x84 three times -> 0x11, 0x22, 0x33; status after the third read = 0x00000005 (empty, last_popped).
- Stream 5 beats with sm_tvalid held high, FIFO_DEPTH=4 -> sm_tready=0 after 4 accepts; status = 0x00000042; one 0x84 read returns beat 1; sm_tready returns to 1 the next cycle; beat 5 is accepted.
- Read 0x84 on an empty FIFO -> data 0, count stays 0, status = 0x00000009; write 0x90=1 -> status = 0x00000001.
- Push on the same cycle as the pop edge at count=2 -> count stays 2, data order preserved; flush on the same cycle as a push -> count 0.
- With AXISOUT_FRAME_CNT_EN: two frames of 2 beats each fully popped -> 0x98 reads 0x00000002; without the macro -> 0x98 reads 0.
